// File: rtl/fb_pkg.sv
// Shared types and widths for the framebuffer write/read masters.
package fb_pkg;

  localparam int FB_ADDR_W  = 29;
  localparam int FB_DATA_W  = 64;
  localparam int FB_BURST_W = 8;
  localparam int FB_PIX_W   = 32;
  localparam logic [7:0] FB_BE_ALL = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } fb_state_t;

  // Pixel word 0x00RRGGBB, also used by framebuffer_read
  typedef logic [FB_PIX_W-1:0] fb_pixel_t;

endpackage

// File: rtl/fb_write_fifo.sv
// Show-ahead FIFO between pixel packing and the Avalon burst side.
// data_o always presents the head entry; pop_i consumes it.
module fb_write_fifo #(
  parameter int DEPTH = 64,
  parameter int W     = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // Storage array; contents are don't-care until written
  always_ff @(posedge clock) begin
    if (push_i) mem[wr_ptr_q] <= data_i;
  end

  // Pointers and occupancy; simultaneous push/pop leaves count unchanged
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

endmodule

// File: rtl/framebuffer_write.sv
// Avalon-MM burst write master: packs pixel pairs into 64-bit words and
// writes a whole frame into the selected SDRAM framebuffer.
//
// state | meaning
// IDLE  | waiting for frame_start
// FILL  | waiting until the FIFO holds the next burst's words
// BURST | issuing beats; write stays high until the last beat is taken
// DONE  | frame_done pulse, busy drops
module framebuffer_write
  import fb_pkg::*;
#(
  parameter int                   WIDTH      = 640,
  parameter int                   HEIGHT     = 480,
  parameter logic [FB_ADDR_W-1:0] BUF0_BASE  = 29'h0400000,
  parameter logic [FB_ADDR_W-1:0] BUF1_BASE  = 29'h0500000,
  parameter int                   BURST_LEN  = 16,
  parameter int                   FIFO_DEPTH = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  buffer,
  input  logic                  frame_start,
  input  fb_pixel_t             pixel_in,
  input  logic                  pixel_valid,
  output logic                  pixel_ready,
  output logic [FB_ADDR_W-1:0]  address,
  output logic [FB_BURST_W-1:0] burstcount,
  output logic [FB_DATA_W-1:0]  writedata,
  output logic [7:0]            byteenable,
  output logic                  write,
  input  logic                  waitrequest,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int TOTAL_PIX   = WIDTH * HEIGHT;
  localparam int TOTAL_WORDS = TOTAL_PIX / 2;
  localparam int PIX_W       = $clog2(TOTAL_PIX + 1);
  localparam int WL_W        = $clog2(TOTAL_WORDS + 1);
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;

  fb_state_t             state_q;
  logic [FB_ADDR_W-1:0]  base_q, address_q;
  logic [WL_W-1:0]       words_left_q;
  logic [FB_BURST_W-1:0] burstcount_q, beats_left_q;
  logic                  write_q, busy_q, frame_done_q;

  logic [PIX_W-1:0]      pix_cnt_q, pix_cnt_d;
  fb_pixel_t             lo_q, lo_d;

  logic                  fifo_full;
  logic [CNT_W-1:0]      fifo_count;
  logic [FB_DATA_W-1:0]  fifo_head;

  logic                  pix_acc, push, pop;
  logic [31:0]           nb;

  // Ready depends only on registered state, never on pixel_valid
  assign pixel_ready = (state_q != IDLE) && !fifo_full &&
                       (32'(pix_cnt_q) < 32'(TOTAL_PIX));
  assign pix_acc = pixel_valid && pixel_ready;
  // Odd-numbered pixel (count bit 0 set) completes the word
  assign push    = pix_acc && pix_cnt_q[0];
  assign pop     = write_q && !waitrequest;
  assign nb      = (32'(words_left_q) < 32'(BURST_LEN)) ? 32'(words_left_q)
                                                        : 32'(BURST_LEN);

  fb_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FB_DATA_W),
    .CW    (CNT_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  ({pixel_in, lo_q}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // Pixel counter and first-of-pair latch next state
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    lo_d      = lo_q;
    if (state_q == IDLE && frame_start) begin
      pix_cnt_d = '0;
    end else if (pix_acc) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
      if (!pix_cnt_q[0]) lo_d = pixel_in;
    end
  end

  // Pixel intake registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt_q <= '0;
      lo_q      <= '0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      lo_q      <= lo_d;
    end
  end

  // Burst sequencing FSM with registered Avalon outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      address_q    <= '0;
      words_left_q <= '0;
      burstcount_q <= '0;
      beats_left_q <= '0;
      write_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            base_q       <= buffer ? BUF1_BASE : BUF0_BASE;
            words_left_q <= WL_W'(TOTAL_WORDS);
            busy_q       <= 1'b1;
            state_q      <= FILL;
          end
        end
        FILL: begin
          // Start only once every beat of the burst is already buffered
          if (32'(fifo_count) >= nb) begin
            address_q    <= base_q;
            burstcount_q <= FB_BURST_W'(nb);
            beats_left_q <= FB_BURST_W'(nb);
            write_q      <= 1'b1;
            state_q      <= BURST;
          end
        end
        BURST: begin
          if (pop) begin
            beats_left_q <= beats_left_q - 1'b1;
            if (beats_left_q == 8'd1) begin
              write_q      <= 1'b0;
              base_q       <= base_q + FB_ADDR_W'(burstcount_q);
              words_left_q <= words_left_q - WL_W'(burstcount_q);
              if (32'(words_left_q) == 32'(burstcount_q)) begin
                state_q      <= DONE;
                frame_done_q <= 1'b1;
              end else begin
                state_q <= FILL;
              end
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign address    = address_q;
  assign burstcount = burstcount_q;
  // Gate the FIFO head so the bus is quiet (and zero after reset) between bursts
  assign writedata  = write_q ? fifo_head : '0;
  assign byteenable = write_q ? FB_BE_ALL : 8'h00;
  assign write      = write_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/framebuffer_write.md
Name: framebuffer_write

Overview:
- Avalon-MM burst write master that stores a rendered frame into one of two SDRAM framebuffers. It is the write-side counterpart to the scan-out reader, connected to an HPS f2h SDRAM data port.
- Accepts a valid/ready stream of 32-bit pixels from the rasteriser, packs pixel pairs into 64-bit words and buffers them in a FIFO.
- Issues fixed-length write bursts to the selected buffer's base address until the whole frame is written, then pulses frame_done.

Parameters:
WIDTH, 640, pixels per line
HEIGHT, 480, lines per frame; WIDTH*HEIGHT must be even
BUF0_BASE, 29'h0400000, 64-bit-word address of buffer 0
BUF1_BASE, 29'h0500000, 64-bit-word address of buffer 1
BURST_LEN, 16, beats per full burst (1..128)
FIFO_DEPTH, 64, 64-bit words; power of two, >= 2*BURST_LEN

Ports:
clock  in  1  system clock; all logic is on this edge
reset_n  in  1  asynchronous, active-low reset
buffer  in  1  target buffer select; sampled on accepted frame_start
frame_start  in  1  single-cycle request to begin a frame
pixel_in  in  32  pixel, 0x00RRGGBB
pixel_valid  in  1  pixel_in is valid
pixel_ready  out  1  pixel accepted when pixel_valid && pixel_ready
address  out  29  Avalon word address, held for the whole burst
burstcount  out  8  beats in the current burst, held for the whole burst
writedata  out  64  write data beat
byteenable  out  8  constant 8'hFF while write=1
write  out  1  Avalon write
waitrequest  in  1  Avalon stall
busy  out  1  high from the accepted frame_start through DONE
frame_done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State is IDLE and the FIFO is emptied.
  - All outputs are 0: address, burstcount, writedata, byteenable, write, pixel_ready, busy, frame_done.
  - A burst in flight is abandoned. Reset mid-frame is legal only together with the system reset.
- Constants:
  - TOTAL_WORDS = WIDTH*HEIGHT/2.
  - Counters: pix_cnt counts accepted pixels (width sized for WIDTH*HEIGHT); words_left counts words not yet written.
- Packing:
  - The first pixel of a pair is latched into [31:0].
  - The second pixel completes the word as {second, first], and that word is pushed into the FIFO in the same cycle.
  - No partial words are possible because the pixel count is even.
- pixel_ready = (state != IDLE) && !fifo_full && (pix_cnt < WIDTH*HEIGHT).
  - Not registered against valid; there is no combinational path from pixel_valid.
  - Pixels offered beyond WIDTH*HEIGHT are not accepted.
- IDLE:
  - frame_start=1 moves to FILL.
  - On that transition: base = buffer ? BUF1_BASE : BUF0_BASE, words_left = TOTAL_WORDS, pix_cnt = 0, busy = 1.
  - frame_start in any other state is ignored. It is not queued.
- FILL:
  - nb = min(BURST_LEN, words_left).
  - When fifo_count >= nb, move to BURST next cycle with address = base, burstcount = nb, write = 1.
  - Bursts therefore never start without all their data, and there are no write=0 gaps inside a burst.
- BURST:
  - A beat is accepted when write && !waitrequest. The FIFO pops on acceptance.
  - writedata is the FIFO head (show-ahead FIFO) and changes only after an accepted beat.
  - address and burstcount stay constant for the whole burst.
  - On the last beat: base += burstcount and words_left -= burstcount.
    - If words_left becomes 0, move to DONE.
    - Otherwise go to FILL; write drops for at least one cycle between bursts.
  - waitrequest held high stalls indefinitely with outputs stable.
- DONE: frame_done = 1 for one cycle, busy drops, go to IDLE.
- Throughput:
  - Pixel intake continues during BURST (the FIFO decouples the two sides).
  - Maximum rate is 1 pixel/cycle in, 1 word/cycle out.
- Simultaneous push and pop on the same cycle: fifo_count is unchanged.
  - A push is never attempted when full, because pixel_ready already excludes it.
  - A pop never happens when empty, because FILL guarantees the data is present.
- Tail: if TOTAL_WORDS is not a multiple of BURST_LEN, the last burst is short (burstcount = remainder).
- Address arithmetic is 29-bit and wraps modulo 2^29. It must not wrap for legal parameters.

Decomposition:
- Package fb_pkg holds:
  - FB_ADDR_W=29, FB_DATA_W=64, FB_BURST_W=8, FB_BE_ALL=8'hFF
  - fb_state_t {IDLE, FILL, BURST, DONE}
  - The pixel type (32-bit), shared with framebuffer_read.
- Sub-module fb_write_fifo: synchronous show-ahead FIFO with asynchronous active-low reset and a count output.

Test Plan:
- Basic frame:
  - Setup: WIDTH=8, HEIGHT=4, BURST_LEN=4, buffer=0, BUF0_BASE=0x100, pixels 0..31 at full rate, waitrequest=0.
  - Response: 4 bursts, address 0x100/0x104/0x108/0x10C, burstcount=4.
  - First beat writedata=0x00000001_00000000. frame_done pulses once and busy then drops.
- Tail burst:
  - Setup: WIDTH=10, HEIGHT=1, BURST_LEN=4.
  - Response: bursts of 4 at base and of 1 at base+4. Last writedata={pix9, pix8}.
- Stalls:
  - Stimulus: random waitrequest at 50% plus random pixel_valid gaps.
  - Response: address/burstcount/writedata stable while stalled, beat count = 16, data order preserved, no write=0 mid-burst.
- Buffer select and ignored start:
  - Stimulus: buffer=1 frame, with frame_start re-asserted mid-frame.
  - Response: all addresses start at BUF1_BASE, no restart, exactly one frame_done.
- Backpressure and overrun:
  - Stimulus: waitrequest=1 for 200 cycles with FIFO_DEPTH=8; then offer 40 pixels with WIDTH*HEIGHT=32.
  - Response: pixel_ready drops when the FIFO is full. Exactly 32 pixels accepted, pixel_ready=0 afterwards.
- Reset mid-burst:
  - Stimulus: reset_n low during beat 2.
  - Response: write/busy/pixel_ready go to 0 asynchronously. A new frame_start after reset writes from the base with correct data.
